// File: rtl/isp_lbuf_flush_ctrl.sv
// isp_lbuf_flush_ctrl
// Frame sequencer in front of the 5x5 line-buffered ISP stages. Passes the raw
// sensor stream through one register stage, counts lines of each frame and,
// after the last sensor line, appends FLUSH_LINES zero-valued lines (each
// preceded by HBLANK idle cycles) so downstream line buffers drain their
// bottom rows. Line-length and overlapping-activity violations are flagged
// with sticky error bits.
module isp_lbuf_flush_ctrl #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int FLUSH_LINES = 2,
  parameter int HBLANK      = 16
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_raw,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            flush_active,
  output logic            frame_done,
  output logic            err_len,
  output logic            err_overlap
);

  // The pixel counter carries one spare bit and saturates, so an over-long
  // line can never wrap back onto WIDTH and hide a length error.
  localparam int PIX_W     = $clog2(WIDTH + 1) + 1;
  localparam int LINE_W    = $clog2(HEIGHT + 1);
  localparam int FLUSH_W   = $clog2(FLUSH_LINES + 1);
  localparam int PHASE_MAX = (WIDTH > HBLANK) ? WIDTH : HBLANK;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [PIX_W-1:0]   LINE_LEN   = PIX_W'(WIDTH);
  localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(HEIGHT - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_LINES - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(HBLANK - 1);
  localparam logic [PHASE_W-1:0] FLUSH_LAST = PHASE_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    GAP,
    FLUSH,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               prev_href;
  logic [PIX_W-1:0]   pix_cnt;
  logic [LINE_W-1:0]  line_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [PHASE_W-1:0] phase_cnt;
  logic               line_close;
  logic               phase_last;
  logic               in_flush;

  // In GAP/FLUSH the sensor input is ignored; elsewhere it passes straight through.
  assign in_flush = (state == GAP) || (state == FLUSH);

  // Next-state decode: line closes on href falling edge, phase counter paces GAP/FLUSH, vsync overrides all.
  always_comb begin
    next_state = state;
    line_close = 1'b0;
    phase_last = 1'b0;
    case (state)
      IDLE: next_state = IDLE;
      FRAME: begin
        if (prev_href && !in_href) begin
          line_close = 1'b1;
          if (line_cnt == LAST_LINE) begin
            next_state = GAP;
          end
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) begin
          phase_last = 1'b1;
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (phase_cnt == FLUSH_LAST) begin
          phase_last = 1'b1;
          next_state = (flush_cnt == LAST_FLUSH) ? DONE : GAP;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (in_vsync) begin
      next_state = FRAME;
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Line/pixel/flush counters and the line-length check; vsync restarts counting.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_href <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      flush_cnt <= '0;
      phase_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      prev_href <= in_href;
      if (in_vsync) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        flush_cnt <= '0;
        phase_cnt <= '0;
      end else begin
        case (state)
          FRAME: begin
            if (line_close) begin
              pix_cnt  <= '0;
              line_cnt <= line_cnt + LINE_W'(1);
              if (pix_cnt != LINE_LEN) begin
                err_len <= 1'b1;
              end
            end else if (in_href && (pix_cnt != '1)) begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
          GAP: begin
            phase_cnt <= phase_last ? '0 : phase_cnt + PHASE_W'(1);
          end
          FLUSH: begin
            if (phase_last) begin
              phase_cnt <= '0;
              flush_cnt <= flush_cnt + FLUSH_W'(1);
            end else begin
              phase_cnt <= phase_cnt + PHASE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs, decoded from the state being entered so they line up with it.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href     <= 1'b0;
      out_vsync    <= 1'b0;
      out_raw      <= '0;
      flush_active <= 1'b0;
      frame_done   <= 1'b0;
      err_overlap  <= 1'b0;
    end else begin
      out_vsync    <= in_vsync;
      out_href     <= (next_state == FLUSH) || (!in_flush && in_href);
      out_raw      <= (!in_flush && in_href) ? in_raw : '0;
      flush_active <= (next_state == GAP) || (next_state == FLUSH);
      frame_done   <= (next_state == DONE);
      if (in_flush && (in_href || in_vsync)) begin
        err_overlap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isp_lbuf_flush_ctrl.sv
// tb_isp_lbuf_flush_ctrl
// Directed scenarios for the flush sequencer. Each stimulus cycle pushes the
// hand-derived expected output of that cycle into a queue; a monitor on the
// falling clock edge pops and compares it against what the DUT presents.
module tb_isp_lbuf_flush_ctrl;

  localparam int BITS        = 8;
  localparam int WIDTH       = 8;
  localparam int HEIGHT      = 4;
  localparam int FLUSH_LINES = 2;
  localparam int HBLANK      = 3;
  localparam int LINE_BLANK  = 5;

  logic            pclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_href = 1'b0;
  logic            in_vsync = 1'b0;
  logic [BITS-1:0] in_raw = '0;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_raw;
  logic            flush_active;
  logic            frame_done;
  logic            err_len;
  logic            err_overlap;

  typedef struct packed {
    logic            href;
    logic            vsync;
    logic [BITS-1:0] raw;
    logic            fa;
    logic            fd;
    logic            len;
    logic            ovl;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  int              checks = 0;
  int              errors = 0;
  logic            e_len = 1'b0;
  logic            e_ovl = 1'b0;
  logic [BITS-1:0] pix_val;

  isp_lbuf_flush_ctrl #(
    .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .FLUSH_LINES(FLUSH_LINES), .HBLANK(HBLANK)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .in_raw(in_raw), .out_href(out_href), .out_vsync(out_vsync),
    .out_raw(out_raw), .flush_active(flush_active), .frame_done(frame_done),
    .err_len(err_len), .err_overlap(err_overlap)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " out_href"}, out_href, 0);
    checkOutput({tag, " out_vsync"}, out_vsync, 0);
    checkOutput({tag, " out_raw"}, out_raw, 0);
    checkOutput({tag, " flush_active"}, flush_active, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " err_len"}, err_len, 0);
    checkOutput({tag, " err_overlap"}, err_overlap, 0);
  endtask

  // One clock of stimulus; the expectation for the following cycle is queued after the edge.
  task automatic applyStimulus(input logic href, input logic vsync, input logic [BITS-1:0] raw,
                               input logic ehref, input logic [BITS-1:0] eraw,
                               input logic efa, input logic efd);
    exp_t e;
    in_href  = href;
    in_vsync = vsync;
    in_raw   = raw;
    @(posedge pclk);
    #1;
    e.href  = ehref;
    e.vsync = vsync;
    e.raw   = eraw;
    e.fa    = efa;
    e.fd    = efd;
    e.len   = e_len;
    e.ovl   = e_ovl;
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic vsync_step();
    applyStimulus(1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Sensor lines; the step after a line's last pixel is its falling edge.
  task automatic send_lines(input int n_lines, input int short_line, input bit counted, input bit trailing_blank);
    int npix;
    pix_val = 1;
    for (int l = 1; l <= n_lines; l++) begin
      npix = (l == short_line) ? WIDTH - 1 : WIDTH;
      for (int i = 0; i < npix; i++) begin
        applyStimulus(1'b1, 1'b0, pix_val, 1'b1, pix_val, 1'b0, 1'b0);
        pix_val++;
      end
      if (l < n_lines || trailing_blank) begin
        for (int b = 0; b < LINE_BLANK; b++) begin
          if (b == 0 && counted && npix != WIDTH) e_len = 1'b1;
          applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        end
      end
    end
  endtask

  // Expected tail of a frame: (HBLANK low + WIDTH zero pixels) per flush line, then frame_done.
  task automatic flush_seq(input bit intrude);
    logic h;
    for (int k = 0; k < FLUSH_LINES; k++) begin
      for (int g = 0; g < HBLANK; g++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      for (int p = 0; p < WIDTH; p++) begin
        h = intrude && (k == 1) && (p >= 2) && (p <= 4);
        if (h) e_ovl = 1'b1;
        applyStimulus(h, 1'b0, h ? 8'hAA : 8'h00, 1'b1, '0, 1'b1, 1'b0);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge.
  initial begin
    forever begin
      @(negedge pclk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("out_href", out_href, mon_e.href);
        checkOutput("out_vsync", out_vsync, mon_e.vsync);
        checkOutput("out_raw", out_raw, mon_e.raw);
        checkOutput("flush_active", flush_active, mon_e.fa);
        checkOutput("frame_done", frame_done, mon_e.fd);
        checkOutput("err_len", err_len, mon_e.len);
        checkOutput("err_overlap", err_overlap, mon_e.ovl);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    repeat (2) @(posedge pclk);
    #1;
    check_all_zero("reset");
    @(negedge pclk);
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    $display("[TB] clean frame");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    flush_seq(1'b0);
    idle_steps(3);

    $display("[TB] short line");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 2, 1'b1, 1'b0);
    flush_seq(1'b0);
    idle_steps(3);

    $display("[TB] overlap by href");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    flush_seq(1'b1);
    idle_steps(3);

    $display("[TB] overlap by vsync");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    e_ovl = 1'b1;
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    flush_seq(1'b0);
    idle_steps(3);

    $display("[TB] reset mid-flush");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    for (int g = 0; g < HBLANK; g++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) applyStimulus(1'b0, 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);
    @(negedge pclk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    e_len = 1'b0;
    e_ovl = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    @(posedge pclk);
    #1;
    send_lines(HEIGHT, 0, 1'b0, 1'b1);
    idle_steps(30);

    $display("[TB] back-to-back frames");
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    flush_seq(1'b0);
    idle_steps(1);
    vsync_step();
    idle_steps(2);
    send_lines(HEIGHT, 0, 1'b1, 1'b0);
    flush_seq(1'b0);
    idle_steps(3);

    repeat (2) @(negedge pclk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isp_lbuf_flush_ctrl.md
# isp_lbuf_flush_ctrl

Frame sequencer placed in front of the 5x5 line-buffered ISP stages, such as the green interpolation and demosaic filters. It passes the sensor raw stream through with one register stage and counts lines and pixels per frame. After the last sensor line of a frame it injects FLUSH_LINES synthetic zero-valued lines, separated by HBLANK idle cycles, so the downstream line buffers drain the bottom rows of the window. It also flags protocol violations: line-length errors and a new frame arriving while a flush is still running.

## Interface
- BITS, 8, raw pixel width
- WIDTH, 1280, active pixels per line; also the length of each flush line
- HEIGHT, 960, sensor lines per frame
- FLUSH_LINES, 2, synthetic lines appended per frame (>=1)
- HBLANK, 16, href-low cycles before each flush line (>=1)

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_href  in  1  line valid, active high
- in_vsync  in  1  frame sync, active-high level
- in_raw  in  BITS  raw Bayer pixel
- out_href  out  1  line valid to downstream stage
- out_vsync  out  1  in_vsync delayed 1 cycle
- out_raw  out  BITS  pixel to downstream; 0 whenever out_href=0
- flush_active  out  1  high while in GAP or FLUSH state
- frame_done  out  1  one-cycle pulse after the last flush pixel
- err_len  out  1  sticky; a sensor line length was not equal to WIDTH
- err_overlap  out  1  sticky; input activity arrived during a flush

## Operation
- States: IDLE, FRAME, GAP, FLUSH, DONE. All outputs are registered.
- Reset (async): state=IDLE. All counters are 0. Every output is 0.
- Priority rule: in_vsync=1 in any state forces FRAME on the next cycle and clears line_cnt, pix_cnt and flush_cnt. If the state was GAP or FLUSH, err_overlap is also set. A vsync arriving during a flush therefore aborts it.
- IDLE and FRAME, pass-through:
  - out_href <= in_href.
  - out_raw <= in_href ? in_raw : 0.
- FRAME counting:
  - pix_cnt increments on every in_href=1 cycle.
  - A falling edge (registered prev_href=1, in_href=0) closes the line. If pix_cnt != WIDTH, err_len is set. pix_cnt is then cleared and line_cnt increments.
  - When the closing line is line number HEIGHT, the next state is GAP.
- IDLE counting: input lines are passed through but not counted.
- GAP:
  - out_href=0 and out_raw=0.
  - Runs for HBLANK cycles, then moves to FLUSH.
- FLUSH:
  - out_href=1 and out_raw=0 for exactly WIDTH cycles.
  - Then flush_cnt increments. If flush_cnt < FLUSH_LINES the next state is GAP; otherwise it is DONE.
- DONE: lasts one cycle with frame_done=1, then IDLE.
- In GAP or FLUSH, in_href=1 is dropped (it does not reach the output) and sets err_overlap.
- err_len and err_overlap clear only on reset.
- Counter widths: clog2 of the maximum value plus 1. Counters never wrap within a legal frame.

## Timing
- Pass-through latency is 1 cycle for href, vsync and raw.
- End of frame, with the falling edge of sensor line HEIGHT sampled at edge t:
  - The state is GAP for cycles t+1 .. t+HBLANK.
  - The output therefore shows exactly HBLANK href-low cycles after the last real pixel.
  - FLUSH line 1 has out_href=1 for cycles t+HBLANK+1 .. t+HBLANK+WIDTH.
  - Each subsequent flush line is preceded by HBLANK low cycles.
- frame_done is high for one cycle, the cycle after the last flush pixel, with out_href=0.
- flush_active goes high the first GAP cycle and low in the DONE cycle.
- Total added cycles per frame: FLUSH_LINES*(HBLANK+WIDTH)+1.
- A vsync sampled at edge v aborts a flush: out_href=0 and flush_active=0 from cycle v+1.
- Reset mid-flush: outputs are 0 immediately (async). After release, the block waits in IDLE for the next in_vsync.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, FLUSH_LINES=2, HBLANK=3, BITS=8.

1. Clean frame: a vsync pulse, then 4 lines of 8 pixels (values 1..32) with a 5-cycle blank between lines.
   - out_raw equals the input delayed 1 cycle.
   - The frame is followed by two flush lines: 3 low cycles + 8 high cycles with out_raw=0, twice.
   - frame_done pulses exactly once, 1 cycle after the 16th flush pixel.
   - err_len=0 and err_overlap=0.
2. Short line: line 2 carries 7 pixels.
   - err_len=1 from the cycle after that line's falling edge, and it stays 1.
   - Flushing still starts after line 4.
3. Overlap by href: in_href is driven high during the second flush line.
   - err_overlap=1.
   - out_href stays a clean 8-cycle flush, and out_raw=0 throughout.
4. Overlap by vsync: in_vsync is asserted during the first GAP.
   - err_overlap=1, flush_active falls next cycle, and no frame_done pulse is produced.
   - The next 4 lines are counted as a new frame and flushed normally.
5. Reset mid-FLUSH: rst_n is pulled low asynchronously.
   - All outputs are 0 within the same cycle.
   - After release, lines without a preceding vsync pass through uncounted and produce no flush.
6. Back-to-back frames: a vsync arrives 2 cycles after frame_done.
   - The second frame is processed identically to scenario 1.
   - err_overlap=0.
